// File: rtl/ram_port_arbiter_if.sv
// Requester-side bus of the RAM port arbiter: one instance per requester.
interface ram_port_arbiter_if;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter with burst cap sharing one synchronous RAM port between
// two requesters; returns read data to the issuing requester two cycles after grant.
module ram_port_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  ram_port_arbiter_if.slave   port0,
  ram_port_arbiter_if.slave   port1,
  output logic                ram_we,
  output logic [7:0]          ram_addr,
  output logic [7:0]          ram_wd,
  input  logic [7:0]          ram_dout
);
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  logic              owner;
  logic [CNT_W-1:0]  burst_cnt;
  logic              rd_pend;
  logic              rd_id;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_wd;
  logic              rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  logic              grant;
  logic              winner;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wd;

  // Winner selection: owner keeps the port under contention until its burst cap.
  always_comb begin
    grant  = 1'b0;
    winner = owner;
    if (!rst) begin
      case ({port1.req, port0.req})
        2'b01:   begin grant = 1'b1; winner = 1'b0; end
        2'b10:   begin grant = 1'b1; winner = 1'b1; end
        2'b11:   begin
          grant  = 1'b1;
          winner = (burst_cnt < BURST_MAX) ? owner : ~owner;
        end
        default: begin grant = 1'b0; winner = owner; end
      endcase
    end
  end

  // RAM port mux and grants; address/data hold the last grant when idle.
  always_comb begin
    win_we    = winner ? port1.we    : port0.we;
    win_addr  = winner ? port1.addr  : port0.addr;
    win_wd    = winner ? port1.wdata : port0.wdata;
    ram_we    = grant & win_we;
    ram_addr  = grant ? win_addr : last_addr;
    ram_wd    = grant ? win_wd   : last_wd;
    port0.gnt = grant & ~winner;
    port1.gnt = grant &  winner;
  end

  // Ownership and saturating burst counter; an idle cycle clears the burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= 1'b0;
      burst_cnt <= '0;
      last_addr <= '0;
      last_wd   <= '0;
    end else if (grant) begin
      last_addr <= win_addr;
      last_wd   <= win_wd;
      if (winner == owner) begin
        burst_cnt <= (burst_cnt < BURST_MAX) ? burst_cnt + CNT_W'(1) : BURST_MAX;
      end else begin
        owner     <= winner;
        burst_cnt <= CNT_W'(1);
      end
    end else begin
      burst_cnt <= '0;
    end
  end

  // Read-return pipeline: capture ram_dout one cycle after a read grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend   <= 1'b0;
      rd_id     <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rd_pend   <= grant & ~win_we;
      rd_id     <= winner;
      rvalid0_q <= rd_pend & ~rd_id;
      rvalid1_q <= rd_pend &  rd_id;
      if (rd_pend && !rd_id) rdata0_q <= ram_dout;
      if (rd_pend &&  rd_id) rdata1_q <= ram_dout;
    end
  end

  assign port0.rvalid = rvalid0_q;
  assign port0.rdata  = rdata0_q;
  assign port1.rvalid = rvalid1_q;
  assign port1.rdata  = rdata1_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter (MAX_BURST=2) with a behavioural
// 256x8 RAM port: registered address/write, combinational read.
module tb_ram_port_arbiter;
  logic       clk;
  logic       rst;
  logic       ram_we;
  logic [7:0] ram_addr;
  logic [7:0] ram_wd;
  logic [7:0] ram_dout;

  ram_port_arbiter_if p0 ();
  ram_port_arbiter_if p1 ();

  ram_port_arbiter #(.MAX_BURST(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .port0    (p0),
    .port1    (p1),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_wd   (ram_wd),
    .ram_dout (ram_dout)
  );

  // RAM model: write and address registered on the edge, read from registered address.
  logic [7:0] mem [256];
  logic [7:0] ram_aq;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wd;
    ram_aq <= ram_addr;
  end
  assign ram_dout = mem[ram_aq];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drv0(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
    p0.req = r; p0.we = w; p0.addr = a; p0.wdata = d;
  endtask

  task automatic drv1(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
    p1.req = r; p1.we = w; p1.addr = a; p1.wdata = d;
  endtask

  task automatic idle();
    drv0(1'b0, 1'b0, 8'h00, 8'h00);
    drv1(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic nextc();
    @(posedge clk);
    #1;
  endtask

  logic exp_g [6];
  logic src1;

  initial begin
    rst = 1'b1;
    drv0(1'b1, 1'b1, 8'h10, 8'hA5);
    drv1(1'b1, 1'b1, 8'h10, 8'h5A);
    nextc();
    // Reset: no grants or writes even with requests present
    check("rst_gnt0",    8'(p0.gnt),    8'h0);
    check("rst_gnt1",    8'(p1.gnt),    8'h0);
    check("rst_ram_we",  8'(ram_we),    8'h0);
    check("rst_rvalid0", 8'(p0.rvalid), 8'h0);
    check("rst_rvalid1", 8'(p1.rvalid), 8'h0);
    check("rst_rdata0",  p0.rdata,      8'h00);
    check("rst_rdata1",  p1.rdata,      8'h00);
    rst = 1'b0;
    idle();
    nextc();

    // Test 1: write then read back on port 0
    drv0(1'b1, 1'b1, 8'h10, 8'hA5);
    @(negedge clk);
    check("t1_wr_gnt0",   8'(p0.gnt), 8'h1);
    check("t1_wr_gnt1",   8'(p1.gnt), 8'h0);
    check("t1_wr_ram_we", 8'(ram_we), 8'h1);
    check("t1_wr_addr",   ram_addr,   8'h10);
    check("t1_wr_wd",     ram_wd,     8'hA5);
    nextc();
    drv0(1'b1, 1'b0, 8'h10, 8'h00);
    @(negedge clk);
    check("t1_rd_gnt0",   8'(p0.gnt), 8'h1);
    check("t1_rd_ram_we", 8'(ram_we), 8'h0);
    nextc();
    idle();
    @(negedge clk);
    check("t1_idle_gnt0",    8'(p0.gnt),    8'h0);
    check("t1_idle_ram_we",  8'(ram_we),    8'h0);
    check("t1_idle_addr",    ram_addr,      8'h10);
    check("t1_early_rvalid", 8'(p0.rvalid), 8'h0);
    nextc();
    @(negedge clk);
    check("t1_rvalid0", 8'(p0.rvalid), 8'h1);
    check("t1_rdata0",  p0.rdata,      8'hA5);
    check("t1_rvalid1", 8'(p1.rvalid), 8'h0);
    nextc();
    @(negedge clk);
    check("t1_rvalid0_pulse", 8'(p0.rvalid), 8'h0);
    check("t1_rdata0_hold",   p0.rdata,      8'hA5);
    nextc();

    // Preload 0x01=C1, 0x02=C2 through port 0
    drv0(1'b1, 1'b1, 8'h01, 8'hC1);
    nextc();
    drv0(1'b1, 1'b1, 8'h02, 8'hC2);
    nextc();
    idle();
    nextc();

    // Test 2: continuous contention, MAX_BURST=2 -> 0,0,1,1,0,0
    exp_g = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 8; k++) begin
      if (k < 6) begin
        drv0(1'b1, 1'b0, 8'h01, 8'h00);
        drv1(1'b1, 1'b0, 8'h02, 8'h00);
      end else begin
        idle();
      end
      @(negedge clk);
      if (k < 6) begin
        check($sformatf("t2_gnt0_%0d", k), 8'(p0.gnt), 8'(!exp_g[k]));
        check($sformatf("t2_gnt1_%0d", k), 8'(p1.gnt), 8'(exp_g[k]));
      end
      if (k >= 2) begin
        src1 = exp_g[k-2];
        check($sformatf("t2_rvalid0_%0d", k), 8'(p0.rvalid), 8'(!src1));
        check($sformatf("t2_rvalid1_%0d", k), 8'(p1.rvalid), 8'(src1));
        check($sformatf("t2_rdata_%0d", k), src1 ? p1.rdata : p0.rdata, src1 ? 8'hC2 : 8'hC1);
      end else begin
        check($sformatf("t2_norv_%0d", k), 8'(p0.rvalid | p1.rvalid), 8'h0);
      end
      nextc();
    end

    // Test 3: lone requester 1 gets every cycle; then contention goes to port 0
    for (int k = 0; k < 9; k++) begin
      if (k < 6) begin
        drv0(1'b0, 1'b0, 8'h00, 8'h00);
        drv1(1'b1, 1'b0, 8'h02, 8'h00);
      end else if (k == 6) begin
        drv0(1'b1, 1'b0, 8'h01, 8'h00);
        drv1(1'b1, 1'b0, 8'h02, 8'h00);
      end else begin
        idle();
      end
      @(negedge clk);
      if (k < 7) begin
        check($sformatf("t3_gnt0_%0d", k), 8'(p0.gnt), 8'(k == 6));
        check($sformatf("t3_gnt1_%0d", k), 8'(p1.gnt), 8'(k < 6));
      end
      if (k >= 2) begin
        src1 = (k - 2) < 6;
        check($sformatf("t3_rvalid1_%0d", k), 8'(p1.rvalid), 8'(src1));
        check($sformatf("t3_rvalid0_%0d", k), 8'(p0.rvalid), 8'(!src1));
        check($sformatf("t3_rdata_%0d", k), src1 ? p1.rdata : p0.rdata, src1 ? 8'hC2 : 8'hC1);
      end
      nextc();
    end

    // Test 4: preload 0x20/0x21, then write-vs-read contention on 0x20
    drv0(1'b1, 1'b1, 8'h20, 8'h11);
    nextc();
    drv0(1'b1, 1'b1, 8'h21, 8'h22);
    nextc();
    idle();
    nextc();
    drv0(1'b1, 1'b1, 8'h20, 8'h33);
    drv1(1'b1, 1'b0, 8'h20, 8'h00);
    @(negedge clk);
    check("t4_gnt0",   8'(p0.gnt), 8'h1);
    check("t4_gnt1",   8'(p1.gnt), 8'h0);
    check("t4_ram_we", 8'(ram_we), 8'h1);
    check("t4_ram_wd", ram_wd,     8'h33);
    nextc();
    drv0(1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    check("t4_gnt1_next", 8'(p1.gnt), 8'h1);
    check("t4_rd_addr",   ram_addr,   8'h20);
    check("t4_rd_we",     8'(ram_we), 8'h0);
    nextc();
    idle();
    @(negedge clk);
    check("t4_rv1_early", 8'(p1.rvalid), 8'h0);
    nextc();
    @(negedge clk);
    check("t4_rvalid1",  8'(p1.rvalid), 8'h1);
    check("t4_rdata1",   p1.rdata,      8'h33);
    check("t4_rvalid0",  8'(p0.rvalid), 8'h0);
    check("t4_rdata0_h", p0.rdata,      8'hC1);
    nextc();

    // Test 6: idle cycle writes nothing and clears the burst count
    drv1(1'b1, 1'b0, 8'h21, 8'h00);
    @(negedge clk);
    check("t6_a_gnt1", 8'(p1.gnt), 8'h1);
    nextc();
    nextc();
    idle();
    @(negedge clk);
    check("t6_idle_we",   8'(ram_we),    8'h0);
    check("t6_idle_gnt",  8'(p0.gnt | p1.gnt), 8'h0);
    check("t6_idle_addr", ram_addr,      8'h21);
    check("t6_c_rvalid1", 8'(p1.rvalid), 8'h1);
    check("t6_c_rdata1",  p1.rdata,      8'h22);
    nextc();
    drv0(1'b1, 1'b0, 8'h20, 8'h00);
    drv1(1'b1, 1'b0, 8'h21, 8'h00);
    @(negedge clk);
    check("t6_d_gnt1",    8'(p1.gnt),    8'h1);
    check("t6_d_gnt0",    8'(p0.gnt),    8'h0);
    check("t6_d_rvalid1", 8'(p1.rvalid), 8'h1);
    nextc();
    @(negedge clk);
    check("t6_e_gnt1",  8'(p1.gnt), 8'h1);
    check("t6_e_norv",  8'(p0.rvalid | p1.rvalid), 8'h0);
    nextc();
    @(negedge clk);
    check("t6_f_gnt0",    8'(p0.gnt),    8'h1);
    check("t6_f_gnt1",    8'(p1.gnt),    8'h0);
    check("t6_f_rvalid1", 8'(p1.rvalid), 8'h1);
    check("t6_f_rdata1",  p1.rdata,      8'h22);
    nextc();
    idle();
    @(negedge clk);
    check("t6_g_rvalid1", 8'(p1.rvalid), 8'h1);
    check("t6_g_rdata1",  p1.rdata,      8'h22);
    nextc();
    @(negedge clk);
    check("t6_h_rvalid0", 8'(p0.rvalid), 8'h1);
    check("t6_h_rdata0",  p0.rdata,      8'h33);
    nextc();

    // Test 5: reset one cycle after a read grant discards the read
    drv1(1'b1, 1'b0, 8'h21, 8'h00);
    @(negedge clk);
    check("t5_gnt1", 8'(p1.gnt), 8'h1);
    nextc();
    rst = 1'b1;
    drv0(1'b1, 1'b1, 8'h55, 8'hEE);
    drv1(1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    check("t5_rvalid0", 8'(p0.rvalid), 8'h0);
    check("t5_rvalid1", 8'(p1.rvalid), 8'h0);
    check("t5_rdata0",  p0.rdata,      8'h00);
    check("t5_rdata1",  p1.rdata,      8'h00);
    check("t5_gnt0",    8'(p0.gnt),    8'h0);
    check("t5_ram_we",  8'(ram_we),    8'h0);
    nextc();
    rst = 1'b0;
    idle();
    @(negedge clk);
    check("t5_post_rv_a", 8'(p0.rvalid | p1.rvalid), 8'h0);
    nextc();
    @(negedge clk);
    check("t5_post_rv_b", 8'(p0.rvalid | p1.rvalid), 8'h0);
    nextc();
    drv0(1'b1, 1'b0, 8'h10, 8'h00);
    drv1(1'b1, 1'b0, 8'h21, 8'h00);
    @(negedge clk);
    check("t5_cont_gnt0", 8'(p0.gnt), 8'h1);
    check("t5_cont_gnt1", 8'(p1.gnt), 8'h0);
    nextc();
    idle();
    nextc();
    @(negedge clk);
    check("t5_rvalid0_rd", 8'(p0.rvalid), 8'h1);
    check("t5_rdata0_rd",  p0.rdata,      8'hA5);
    check("t5_mem55",      mem[8'h55] === 8'hEE ? 8'h1 : 8'h0, 8'h0);
    nextc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
